timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set counter, TDR and TCNT width.
REQ-002 PCLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 PRESET  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 Clock_counter  in  1  SHALL be the prescaled clock level from the clock-select block (unedged).
REQ-005 Cks_in  in  2  SHALL be the requested prescaler select (00:/2 01:/4 10:/8 11:/16).
REQ-006 Cks  out  2  SHALL be the applied select driven to the clock-select block.
REQ-007 En  in  1  SHALL be the count enable (level).
REQ-008 Up_dn  in  1  SHALL be the direction: 0 up, 1 down.
REQ-009 Load  in  1  SHALL be a one-cycle request to load TDR into TCNT.
REQ-010 TDR  in  CNT_W  SHALL be the load/reload value.
REQ-011 TCNT  out  CNT_W  SHALL be the counter value.
REQ-012 Ovf, Udf  out  1 each  SHALL be sticky overflow/underflow flags.
REQ-013 Clr_ovf, Clr_udf  in  1 each  SHALL clear the matching flag.
REQ-014 Ie  in  1; Irq  out  1  SHALL be interrupt enable and interrupt output.

Function
REQ-015 Edge detect: register clk_q samples Clock_counter each cycle; tick = Clock_counter & ~clk_q, combinational, one PCLK wide.
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN when En=1; RUN->IDLE and DONE->IDLE when En=0; transition takes one cycle.
REQ-017 Ticks SHALL affect TCNT only in RUN; ignored in IDLE and DONE.
REQ-018 RUN, tick, Up_dn=0: TCNT<=TCNT+1; at all-ones, TCNT<=TDR (reload, no wrap to 0) and Ovf<=1.
REQ-019 RUN, tick, Up_dn=1: TCNT<=TCNT-1; at zero, TCNT<=TDR and Udf<=1.
REQ-020 TCNT SHALL update on the PCLK edge ending the tick cycle (latency 1 cycle from Clock_counter rising as sampled).
REQ-021 Load=1 SHALL set TCNT<=TDR in any state and take priority over a same-cycle tick; no flag set by Load.
REQ-022 Flag set and matching clear in the same cycle: set wins; otherwise clear drops flag next edge.
REQ-023 Irq = Ie & (Ovf | Udf), combinational.
REQ-024 Cks SHALL follow Cks_in every cycle in IDLE/DONE; in RUN it SHALL update only in a tick cycle.
REQ-025 In any cycle where Cks changes value, clk_q SHALL be forced to 1 so the mux switch cannot create a false tick next cycle.
REQ-026 Up_dn change mid-RUN takes effect on the next tick; no other side effect.

Reset
REQ-027 PRESET=1 SHALL immediately force: state IDLE, TCNT=0, Ovf=0, Udf=0, Cks=00, clk_q=0; Irq therefore 0.
REQ-028 Reset asserted mid-count SHALL abandon the count; after release the FSM restarts from IDLE with TCNT=0.

Configuration
REQ-029 Macro TIMER_CTRL_ONESHOT_EN defined: input Oneshot (1 bit) exists; Oneshot=1 makes RUN->DONE on the reload cycle of REQ-018/019 (TCNT=TDR, flag set), staying in DONE until En=0.
REQ-030 Macro undefined: no Oneshot port, no entry into DONE; counter always periodic.

Verification
REQ-031 Reset, TDR=0xFC, Load, Cks_in=00, En=1, Up -> TCNT FD,FE,FF every 2 PCLK, then 0xFC with Ovf=1; Ie=1 -> Irq=1.
REQ-032 TDR=0x02, Load, Up_dn=1, Cks_in=01 -> TCNT 01,00 every 4 PCLK, then 0x02 with Udf=1.
REQ-033 Ovf=1, Clr_ovf pulsed in same cycle as new overflow -> Ovf stays 1; Clr_ovf alone -> Ovf=0 next cycle.
REQ-034 RUN with Cks=00, Cks_in->11 -> Cks changes only on a tick cycle, no extra TCNT step in following cycle, then ticks every 16 PCLK.
REQ-035 Load coinciding with tick at TCNT=0x10, TDR=0x80 -> TCNT=0x80, no increment; PRESET pulse mid-RUN -> TCNT=0, IDLE, flags 0 immediately.
REQ-036 ONESHOT_EN build, Oneshot=1, TDR=0xFE, Up -> one overflow, TCNT holds 0xFE in DONE; En=0 then 1 -> counting resumes.

Source files
------------

// File: rtl/timer_ctrl.sv
// Up/down timer counting edges of a prescaled clock level, with reload, sticky flags and IRQ.
// Optional one-shot mode is compiled in with TIMER_CTRL_ONESHOT_EN.
module timer_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             Clock_counter,
  input  logic [1:0]       Cks_in,
  output logic [1:0]       Cks,
  input  logic             En,
  input  logic             Up_dn,
  input  logic             Load,
  input  logic [CNT_W-1:0] TDR,
  output logic [CNT_W-1:0] TCNT,
  output logic             Ovf,
  output logic             Udf,
  input  logic             Clr_ovf,
  input  logic             Clr_udf,
  input  logic             Ie,
  output logic             Irq
`ifdef TIMER_CTRL_ONESHOT_EN
  ,
  input  logic             Oneshot
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic             clk_q;
  logic [1:0]       cks_q, cks_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, udf_q;
  logic             tick, step, at_lim, wrap, cks_chg, oneshot_hit;

  assign tick = Clock_counter & ~clk_q;

  always_comb begin
    // While running, the prescaler may only switch on a tick so no partial period is counted.
    cks_d   = (state_q == RUN && !tick) ? cks_q : Cks_in;
    cks_chg = (cks_d != cks_q);
    at_lim  = Up_dn ? (cnt_q == '0) : (cnt_q == '1);
    step    = (state_q == RUN) && tick && !Load;
    wrap    = step && at_lim;
    cnt_d   = cnt_q;
    if (Load)
      cnt_d = TDR;
    else if (step)
      cnt_d = at_lim ? TDR : (Up_dn ? cnt_q - ONE : cnt_q + ONE);
`ifdef TIMER_CTRL_ONESHOT_EN
    oneshot_hit = wrap && Oneshot;
`else
    oneshot_hit = 1'b0;
`endif
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      clk_q   <= 1'b0;
      cks_q   <= 2'b00;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      // Mask the level step a mux switch can produce so it is not seen as an edge.
      clk_q <= cks_chg ? 1'b1 : Clock_counter;
      cks_q <= cks_d;
      cnt_q <= cnt_d;
      ovf_q <= (wrap && !Up_dn) || (ovf_q && !Clr_ovf);
      udf_q <= (wrap &&  Up_dn) || (udf_q && !Clr_udf);
      case (state_q)
        IDLE:    if (En) state_q <= RUN;
        RUN:     if (!En) state_q <= IDLE;
                 else if (oneshot_hit) state_q <= DONE;
        DONE:    if (!En) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Cks  = cks_q;
  assign TCNT = cnt_q;
  assign Ovf  = ovf_q;
  assign Udf  = udf_q;
  assign Irq  = Ie & (ovf_q | udf_q);

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_timer_ctrl;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         PCLK, PRESET, Clock_counter;
  logic [1:0]   Cks_in, Cks;
  logic         En, Up_dn, Load, Clr_ovf, Clr_udf, Ie;
  logic [W-1:0] TDR, TCNT;
  logic         Ovf, Udf, Irq;
`ifdef TIMER_CTRL_ONESHOT_EN
  logic         Oneshot;
`endif

  timer_ctrl #(.CNT_W(W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .Clock_counter(Clock_counter),
    .Cks_in(Cks_in), .Cks(Cks), .En(En), .Up_dn(Up_dn), .Load(Load),
    .TDR(TDR), .TCNT(TCNT), .Ovf(Ovf), .Udf(Udf),
    .Clr_ovf(Clr_ovf), .Clr_udf(Clr_udf), .Ie(Ie), .Irq(Irq)
`ifdef TIMER_CTRL_ONESHOT_EN
    , .Oneshot(Oneshot)
`endif
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Clock-select block: free-running divider, output picked by the applied select.
  logic [3:0] div_q = '0;
  always @(posedge PCLK) div_q <= div_q + 4'd1;
  assign Clock_counter = div_q[Cks];

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model
  bit m_running, m_done, m_prev, m_ovf, m_udf;
  int m_cnt, m_cks;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_done = 0; m_prev = 0;
    m_ovf = 0; m_udf = 0; m_cnt = 0; m_cks = 0;
  endtask

  // Called in the active region of a rising edge: sees the pre-edge values of everything.
  task automatic model_step();
    bit cc, tk, wrapped, so, su, one;
    int ncks;
    cc = Clock_counter;
    tk = cc && !m_prev;
    ncks = (m_running && !tk) ? m_cks : int'(Cks_in);
    wrapped = 0; so = 0; su = 0;
    if (Load) m_cnt = TDR;
    else if (m_running && tk) begin
      if (!Up_dn) begin
        if (m_cnt == MAX) begin m_cnt = TDR; so = 1; wrapped = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin m_cnt = TDR; su = 1; wrapped = 1; end
        else m_cnt = m_cnt - 1;
      end
    end
    m_ovf = so || (m_ovf && !Clr_ovf);
    m_udf = su || (m_udf && !Clr_udf);
    m_prev = (ncks != m_cks) ? 1'b1 : cc;
    m_cks = ncks;
    one = 0;
`ifdef TIMER_CTRL_ONESHOT_EN
    one = Oneshot;
`endif
    if (m_running) begin
      if (!En) m_running = 0;
      else if (one && wrapped) begin m_running = 0; m_done = 1; end
    end else if (m_done) begin
      if (!En) m_done = 0;
    end else if (En) m_running = 1;
  endtask

  task automatic compare();
    check("TCNT", int'(TCNT), m_cnt);
    check("Ovf", int'(Ovf), int'(m_ovf));
    check("Udf", int'(Udf), int'(m_udf));
    check("Irq", int'(Irq), int'(Ie && (m_ovf || m_udf)));
    check("Cks", int'(Cks), m_cks);
  endtask

  task automatic cycle();
    @(posedge PCLK);
    model_step();
    @(negedge PCLK);
    compare();
  endtask

  task automatic wait_change(input int maxc, output int cyc);
    logic [W-1:0] v;
    v = TCNT;
    cyc = 0;
    while (TCNT == v && cyc < maxc) begin
      cycle();
      cyc++;
    end
    if (TCNT == v) begin
      n_chk++; n_fail++;
      $display("FAIL wait_change: TCNT stuck at %0h after %0d cycles", v, cyc);
    end
  endtask

  // Asynchronous pulse between edges: outputs must clear without any clock.
  task automatic reset_pulse();
    #1 PRESET = 1'b1;
    #1 model_reset();
    check("rst_TCNT", int'(TCNT), 0);
    check("rst_Ovf", int'(Ovf), 0);
    check("rst_Udf", int'(Udf), 0);
    check("rst_Irq", int'(Irq), 0);
    check("rst_Cks", int'(Cks), 0);
    #1 PRESET = 1'b0;
  endtask

  initial begin
    int c;
    PRESET = 1'b1; Cks_in = 0; En = 0; Up_dn = 0; Load = 0; TDR = 0;
    Clr_ovf = 0; Clr_udf = 0; Ie = 0;
`ifdef TIMER_CTRL_ONESHOT_EN
    Oneshot = 0;
`endif
    model_reset();
    #1;
    check("rst_TCNT", int'(TCNT), 0);
    check("rst_Ovf", int'(Ovf), 0);
    check("rst_Udf", int'(Udf), 0);
    check("rst_Irq", int'(Irq), 0);
    check("rst_Cks", int'(Cks), 0);
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;

    // Count up from 0xFC on /2 through overflow.
    TDR = 8'hFC; Load = 1; En = 1; Ie = 1;
    cycle(); Load = 0;
    check("up_load", int'(TCNT), 'hFC);
    wait_change(4, c);  check("up_1", int'(TCNT), 'hFD);
    wait_change(4, c);  check("up_2", int'(TCNT), 'hFE); check("up_per2", c, 2);
    wait_change(4, c);  check("up_3", int'(TCNT), 'hFF); check("up_per3", c, 2);
    wait_change(4, c);  check("up_rel", int'(TCNT), 'hFC); check("up_per4", c, 2);
    check("up_ovf", int'(Ovf), 1); check("up_irq", int'(Irq), 1);

    // Clear alone drops Ovf on the next edge; then count down on /4.
    En = 0; Cks_in = 2'b01; Clr_ovf = 1;
    cycle(); Clr_ovf = 0;
    check("clr_ovf", int'(Ovf), 0);
    cycle();
    TDR = 8'h02; Load = 1; Up_dn = 1; En = 1;
    cycle(); Load = 0;
    check("dn_load", int'(TCNT), 'h02);
    wait_change(8, c);  check("dn_1", int'(TCNT), 'h01);
    wait_change(8, c);  check("dn_2", int'(TCNT), 'h00); check("dn_per", c, 4);
    wait_change(8, c);  check("dn_rel", int'(TCNT), 'h02); check("dn_per2", c, 4);
    check("dn_udf", int'(Udf), 1);

    // Overflow with Clr_ovf held: set wins in the overflow cycle, clear the cycle after.
    En = 0; Cks_in = 2'b00; Clr_udf = 1;
    cycle(); cycle(); Clr_udf = 0;
    check("clr_udf", int'(Udf), 0);
    TDR = 8'hFE; Load = 1; Up_dn = 0; En = 1; Clr_ovf = 1;
    cycle(); Load = 0;
    wait_change(4, c); check("sc_ff", int'(TCNT), 'hFF);
    wait_change(4, c); check("sc_rel", int'(TCNT), 'hFE);
    check("set_wins", int'(Ovf), 1);
    cycle();
    check("clr_next", int'(Ovf), 0);
    Clr_ovf = 0;

    // Prescaler switch to /16 while running.
    Cks_in = 2'b11;
    c = 0;
    while (Cks != 2'b11 && c < 6) begin cycle(); c++; end
    check("cks_sw", int'(Cks), 3);
    wait_change(40, c);
    wait_change(40, c); check("per16", c, 16);

    // Load colliding with a tick.
    En = 0; Cks_in = 2'b00;
    cycle(); cycle();
    TDR = 8'h0E; Load = 1; En = 1;
    cycle(); Load = 0;
    wait_change(4, c); check("lt_0f", int'(TCNT), 'h0F);
    wait_change(4, c); check("lt_10", int'(TCNT), 'h10);
    cycle();
    TDR = 8'h80; Load = 1;
    cycle(); Load = 0;
    check("lt_load", int'(TCNT), 'h80);
    cycle(); check("lt_hold", int'(TCNT), 'h80);
    cycle(); check("lt_next", int'(TCNT), 'h81);

    // Reset mid-count with a flag set.
    TDR = 8'hFE; Load = 1;
    cycle(); Load = 0;
    wait_change(4, c); wait_change(4, c);
    check("pre_rst_ovf", int'(Ovf), 1);
    reset_pulse();
    cycle();
    check("post_rst", int'(TCNT), 0);

`ifdef TIMER_CTRL_ONESHOT_EN
    En = 0; cycle(); cycle();
    Oneshot = 1; TDR = 8'hFE; Load = 1; En = 1; Up_dn = 0;
    cycle(); Load = 0;
    wait_change(4, c); wait_change(4, c);
    check("os_rel", int'(TCNT), 'hFE); check("os_ovf", int'(Ovf), 1);
    for (int i = 0; i < 10; i++) cycle();
    check("os_hold", int'(TCNT), 'hFE);
    En = 0; cycle(); En = 1;
    wait_change(8, c); check("os_resume", int'(TCNT), 'hFF);
    Oneshot = 0;
`endif

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      En      = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) Up_dn = ~Up_dn;
      Load    = ($urandom_range(0, 23) == 0);
      TDR     = W'($urandom);
      if ($urandom_range(0, 39) == 0) Cks_in = 2'($urandom);
      Clr_ovf = ($urandom_range(0, 7) == 0);
      Clr_udf = ($urandom_range(0, 7) == 0);
      Ie      = $urandom_range(0, 1) == 1;
`ifdef TIMER_CTRL_ONESHOT_EN
      if ($urandom_range(0, 63) == 0) Oneshot = ~Oneshot;
`endif
      cycle();
      if ($urandom_range(0, 499) == 0) reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
